seq_divider: RTL and testbench



---
 rtl/seq_divider_if.sv | 25 ++
 rtl/seq_divider.sv | 129 ++++++++++++
 tb/tb_seq_divider.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/seq_divider_if.sv
// Start/done handshake and operand/result bus for the iterative divider.
// master drives the request side; slave (the divider) drives results.
interface seq_divider_if #(
  parameter int width = 32
);
  logic             start;
  logic             is_signed;
  logic [width-1:0] dividend;
  logic [width-1:0] divisor;
  logic             busy;
  logic             done;
  logic [width-1:0] quotient;
  logic [width-1:0] remainder;
  logic             div_by_zero;

  modport master (
    output start, is_signed, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, is_signed, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/seq_divider.sv
// Restoring divider, one quotient bit per clock; done width+1 cycles after start (1 on divide-by-zero).
// start is only sampled while idle; requests arriving while busy are dropped.
module seq_divider #(
  parameter int width = 32,
  parameter int CNT_W = 6
) (
  input  logic          clk,
  input  logic          rst_n,
  seq_divider_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t           state_q, state_d;
  logic [width-1:0] dvd_q, dvd_d;    // dividend magnitude, shifts out MSB-first as quotient shifts in
  logic [width-1:0] rem_q, rem_d;
  logic [width-1:0] dsr_q, dsr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             neg_q_q, neg_q_d;
  logic             neg_r_q, neg_r_d;
  logic             dz_q, dz_d;
  logic             done_q, done_d;
  logic             dbz_q, dbz_d;
  logic [width-1:0] quot_q, quot_d;
  logic [width-1:0] remo_q, remo_d;

  logic [width:0]   pr_ext;
  logic [width:0]   trial;
  logic             borrow;
  logic             in_zero;
  logic [width-1:0] dvd_mag, dsr_mag;

  assign in_zero = (bus.divisor == '0);
  assign dvd_mag = (bus.is_signed && bus.dividend[width-1]) ? (~bus.dividend + 1'b1) : bus.dividend;
  assign dsr_mag = (bus.is_signed && bus.divisor[width-1])  ? (~bus.divisor + 1'b1)  : bus.divisor;

  // Shifted partial remainder can reach 2*divisor-1, so it carries one extra bit;
  // when that bit is set the trial cannot borrow.
  assign pr_ext = {rem_q, dvd_q[width-1]};
  assign trial  = pr_ext + {1'b1, ~dsr_q} + 1'b1;
  assign borrow = trial[width] & ~pr_ext[width];

  always_comb begin
    state_d = state_q;
    dvd_d   = dvd_q;
    rem_d   = rem_q;
    dsr_d   = dsr_q;
    cnt_d   = cnt_q;
    neg_q_d = neg_q_q;
    neg_r_d = neg_r_q;
    dz_d    = dz_q;
    done_d  = 1'b0;
    dbz_d   = dbz_q;
    quot_d  = quot_q;
    remo_d  = remo_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          neg_q_d = bus.is_signed & (bus.dividend[width-1] ^ bus.divisor[width-1]);
          neg_r_d = bus.is_signed & bus.dividend[width-1];
          dz_d    = in_zero;
          // On divide-by-zero the raw dividend is kept so it can be returned untouched.
          dvd_d   = in_zero ? bus.dividend : dvd_mag;
          dsr_d   = dsr_mag;
          rem_d   = '0;
          cnt_d   = CNT_W'(width - 1);
          state_d = in_zero ? FIX : RUN;
        end
      end
      RUN: begin
        dvd_d = {dvd_q[width-2:0], ~borrow};
        rem_d = borrow ? pr_ext[width-1:0] : trial[width-1:0];
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == '0) state_d = FIX;
      end
      FIX: begin
        if (dz_q) begin
          quot_d = '1;
          remo_d = dvd_q;
          dbz_d  = 1'b1;
        end else begin
          quot_d = neg_q_q ? (~dvd_q + 1'b1) : dvd_q;
          remo_d = neg_r_q ? (~rem_q + 1'b1) : rem_q;
          dbz_d  = 1'b0;
        end
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      dvd_q   <= '0;
      rem_q   <= '0;
      dsr_q   <= '0;
      cnt_q   <= '0;
      neg_q_q <= 1'b0;
      neg_r_q <= 1'b0;
      dz_q    <= 1'b0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
      quot_q  <= '0;
      remo_q  <= '0;
    end else begin
      state_q <= state_d;
      dvd_q   <= dvd_d;
      rem_q   <= rem_d;
      dsr_q   <= dsr_d;
      cnt_q   <= cnt_d;
      neg_q_q <= neg_q_d;
      neg_r_q <= neg_r_d;
      dz_q    <= dz_d;
      done_q  <= done_d;
      dbz_q   <= dbz_d;
      quot_q  <= quot_d;
      remo_q  <= remo_d;
    end
  end

  assign bus.busy        = (state_q != IDLE);
  assign bus.done        = done_q;
  assign bus.quotient    = quot_q;
  assign bus.remainder   = remo_q;
  assign bus.div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider.sv
// Bench for seq_divider: directed scenarios plus randomized operations
// checked against an arithmetic reference model.
module tb_seq_divider;

  logic clk;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  seq_divider_if #(.width(32)) bus ();

  seq_divider #(.width(32), .CNT_W(6)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: plain integer division; signed uses 64-bit so most-negative / -1 wraps naturally.
  function automatic void model(input logic [31:0] a, input logic [31:0] b, input logic s,
                                output logic [31:0] q, output logic [31:0] r, output logic z);
    longint sa, sb;
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF; r = a; z = 1'b1;
    end else if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q = 32'(sa / sb);
      r = 32'(sa % sb);
      z = 1'b0;
    end else begin
      q = a / b; r = a % b; z = 1'b0;
    end
  endfunction

  task automatic start_op(input logic [31:0] a, input logic [31:0] b, input logic s);
    @(negedge clk);
    bus.dividend  = a;
    bus.divisor   = b;
    bus.is_signed = s;
    bus.start     = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  // Returns number of clock edges until done is seen, or -1 after the budget expires.
  task automatic wait_done(output int cyc);
    cyc = -1;
    for (int n = 1; n <= 100; n++) begin
      @(posedge clk);
      #1;
      if (bus.done) begin
        cyc = n;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    bus.start = 1'b0; bus.is_signed = 1'b0; bus.dividend = '0; bus.divisor = '0;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({bus.busy, bus.done, bus.div_by_zero} !== 3'b000) begin
      bad++; $display("FAIL reset_flags: got %b expected 000", {bus.busy, bus.done, bus.div_by_zero});
    end
    total++;
    if ({bus.quotient, bus.remainder} !== 64'd0) begin
      bad++; $display("FAIL reset_results: got %h/%h expected 0/0", bus.quotient, bus.remainder);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic;
    int cyc;
    start_op(32'd100, 32'd7, 1'b0);
    total++;
    if (bus.busy !== 1'b1) begin bad++; $display("FAIL basic_busy: got %b expected 1", bus.busy); end
    wait_done(cyc);
    total++;
    if (cyc != 33) begin bad++; $display("FAIL basic_latency: got %0d expected 33", cyc); end
    total++;
    if (bus.quotient !== 32'd14 || bus.remainder !== 32'd2 || bus.div_by_zero !== 1'b0) begin
      bad++; $display("FAIL basic_result: got %0d r %0d z %b expected 14 r 2 z 0", bus.quotient, bus.remainder, bus.div_by_zero);
    end
    total++;
    if (bus.busy !== 1'b0) begin bad++; $display("FAIL basic_busy_at_done: got %b expected 0", bus.busy); end
    @(posedge clk);
    #1;
    total++;
    if (bus.done !== 1'b0 || bus.quotient !== 32'd14) begin
      bad++; $display("FAIL done_pulse: got done %b q %0d expected done 0 q 14", bus.done, bus.quotient);
    end
  endtask

  task automatic test_signed;
    int cyc;
    start_op(32'hFFFF_FFF9, 32'h2, 1'b1);
    wait_done(cyc);
    total++;
    if (cyc != 33 || bus.quotient !== 32'hFFFF_FFFD || bus.remainder !== 32'hFFFF_FFFF) begin
      bad++; $display("FAIL signed_neg7_2: got cyc %0d %h r %h expected 33 FFFFFFFD r FFFFFFFF", cyc, bus.quotient, bus.remainder);
    end
    start_op(32'hFFFF_FFFF, 32'h1, 1'b0);
    wait_done(cyc);
    total++;
    if (bus.quotient !== 32'hFFFF_FFFF || bus.remainder !== 32'h0) begin
      bad++; $display("FAIL unsigned_max_1: got %h r %h expected FFFFFFFF r 0", bus.quotient, bus.remainder);
    end
  endtask

  task automatic test_div_zero;
    int cyc;
    start_op(32'd5, 32'd0, 1'b0);
    wait_done(cyc);
    total++;
    if (cyc != 1) begin bad++; $display("FAIL dz_latency: got %0d expected 1", cyc); end
    total++;
    if (bus.quotient !== 32'hFFFF_FFFF || bus.remainder !== 32'd5 || bus.div_by_zero !== 1'b1) begin
      bad++; $display("FAIL dz_result: got %h r %h z %b expected FFFFFFFF r 5 z 1", bus.quotient, bus.remainder, bus.div_by_zero);
    end
    start_op(32'd9, 32'd3, 1'b0);
    total++;
    if (bus.div_by_zero !== 1'b1) begin bad++; $display("FAIL dz_held: got %b expected 1", bus.div_by_zero); end
    wait_done(cyc);
    total++;
    if (bus.quotient !== 32'd3 || bus.remainder !== 32'd0 || bus.div_by_zero !== 1'b0) begin
      bad++; $display("FAIL dz_clear: got %0d r %0d z %b expected 3 r 0 z 0", bus.quotient, bus.remainder, bus.div_by_zero);
    end
  endtask

  task automatic test_overflow;
    int cyc;
    start_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    wait_done(cyc);
    total++;
    if (bus.quotient !== 32'h8000_0000 || bus.remainder !== 32'h0 || bus.div_by_zero !== 1'b0) begin
      bad++; $display("FAIL overflow: got %h r %h z %b expected 80000000 r 0 z 0", bus.quotient, bus.remainder, bus.div_by_zero);
    end
  endtask

  task automatic test_back_to_back;
    int cyc;
    start_op(32'd100, 32'd7, 1'b0);
    repeat (10) @(posedge clk);
    @(negedge clk);
    bus.dividend = 32'd50; bus.divisor = 32'd5; bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    wait_done(cyc);
    total++;
    if (cyc < 0 || 11 + cyc != 33) begin bad++; $display("FAIL ignored_latency: got %0d expected 33", 11 + cyc); end
    total++;
    if (bus.quotient !== 32'd14 || bus.remainder !== 32'd2) begin
      bad++; $display("FAIL ignored_start: got %0d r %0d expected 14 r 2", bus.quotient, bus.remainder);
    end
    // Start in the done cycle itself.
    bus.dividend = 32'd50; bus.divisor = 32'd5; bus.is_signed = 1'b0; bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    total++;
    if (bus.busy !== 1'b1 || bus.quotient !== 32'd14) begin
      bad++; $display("FAIL done_cycle_accept: got busy %b q %0d expected busy 1 q 14", bus.busy, bus.quotient);
    end
    wait_done(cyc);
    total++;
    if (cyc != 33 || bus.quotient !== 32'd10 || bus.remainder !== 32'd0) begin
      bad++; $display("FAIL done_cycle_result: got cyc %0d %0d r %0d expected 33 10 r 0", cyc, bus.quotient, bus.remainder);
    end
  endtask

  task automatic test_reset_mid;
    int cyc;
    bit seen;
    start_op(32'd1000, 32'd3, 1'b0);
    repeat (9) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if ({bus.busy, bus.done, bus.div_by_zero} !== 3'b000 || {bus.quotient, bus.remainder} !== 64'd0) begin
      bad++; $display("FAIL reset_mid_clear: got b%b d%b z%b %h/%h expected all 0",
                      bus.busy, bus.done, bus.div_by_zero, bus.quotient, bus.remainder);
    end
    seen = 1'b0;
    repeat (5) begin @(posedge clk); #1; if (bus.done) seen = 1'b1; end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) begin @(posedge clk); #1; if (bus.done || bus.busy) seen = 1'b1; end
    total++;
    if (seen) begin bad++; $display("FAIL reset_mid_nodone: got activity 1 expected 0"); end
    start_op(32'd1000, 32'd3, 1'b0);
    wait_done(cyc);
    total++;
    if (cyc != 33 || bus.quotient !== 32'd333 || bus.remainder !== 32'd1) begin
      bad++; $display("FAIL reset_mid_after: got cyc %0d %0d r %0d expected 33 333 r 1", cyc, bus.quotient, bus.remainder);
    end
  endtask

  task automatic test_random;
    int cyc;
    logic [31:0] a, b, eq, er;
    logic s, ez;
    for (int i = 0; i < 60; i++) begin
      s = 1'($urandom_range(0, 1));
      a = $urandom();
      case ($urandom_range(0, 5))
        0: b = 32'd0;
        1: b = 32'($urandom_range(1, 15));
        2: b = 32'hFFFF_FFFF;
        3: b = $urandom() >> $urandom_range(0, 31);
        default: b = $urandom();
      endcase
      if ($urandom_range(0, 7) == 0) a = 32'h8000_0000;
      if (b == 32'd0 && $urandom_range(0, 1) == 1) b = 32'd1;
      model(a, b, s, eq, er, ez);
      start_op(a, b, s);
      wait_done(cyc);
      total++;
      if (cyc != (ez ? 1 : 33) || bus.quotient !== eq || bus.remainder !== er || bus.div_by_zero !== ez) begin
        bad++;
        $display("FAIL random_%0d: %h/%h s%b got cyc %0d q %h r %h z %b expected cyc %0d q %h r %h z %b",
                 i, a, b, s, cyc, bus.quotient, bus.remainder, bus.div_by_zero, ez ? 1 : 33, eq, er, ez);
      end
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_signed;
    test_div_zero;
    test_overflow;
    test_back_to_back;
    test_reset_mid;
    test_random;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
